// File: rtl/fp_norm_seq.sv
// Sequential normalize-and-pack stage for the single-precision adder.
// It left-normalizes the raw significand sum one bit per cycle, then presents a packed result over valid/ready.
module fp_norm_seq (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [7:0]  in_exp,
    input  logic [24:0] in_sum,
    input  logic        in_inf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic        out_zero,
    output logic        out_inf,
    output logic [4:0]  out_shift
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [24:0] sum_q, sum_d;
    logic        inf_flag_q, inf_flag_d;
    logic [8:0]  exp_q, exp_d;
    logic [4:0]  shift_q, shift_d;
    logic [31:0] result_q, result_d;
    logic        zero_q, zero_d;
    logic        res_inf_q, res_inf_d;
    logic [8:0]  exp_plus;

    assign exp_plus = exp_q + 9'd1;

    always_comb begin
        state_d    = state_q;
        sign_d     = sign_q;
        sum_d      = sum_q;
        inf_flag_d = inf_flag_q;
        exp_d      = exp_q;
        shift_d    = shift_q;
        result_d   = result_q;
        zero_d     = zero_q;
        res_inf_d  = res_inf_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    sign_d     = in_sign;
                    sum_d      = in_sum;
                    inf_flag_d = in_inf;
                    // A zero biased exponent means denormal, which scales like exponent 1.
                    exp_d      = (in_exp == 8'd0) ? 9'd1 : {1'b0, in_exp};
                    shift_d    = 5'd0;
                    state_d    = NORM;
                end
            end
            NORM: begin
                state_d   = DONE;
                zero_d    = 1'b0;
                res_inf_d = 1'b0;
                if (inf_flag_q) begin
                    result_d  = {sign_q, 8'hFF, 23'd0};
                    res_inf_d = 1'b1;
                end else if (sum_q == 25'd0) begin
                    result_d = {sign_q, 8'h00, 23'd0};
                    zero_d   = 1'b1;
                end else if (sum_q[24]) begin
                    // Carry-out: shift right by one and drop the LSB (truncation, no rounding).
                    if (exp_plus == 9'd255) begin
                        result_d  = {sign_q, 8'hFF, 23'd0};
                        res_inf_d = 1'b1;
                    end else begin
                        result_d = {sign_q, exp_plus[7:0], sum_q[23:1]};
                    end
                end else if (sum_q[23]) begin
                    result_d = {sign_q, exp_q[7:0], sum_q[22:0]};
                end else if (exp_q == 9'd1) begin
                    result_d = {sign_q, 8'h00, sum_q[22:0]};
                end else begin
                    sum_d   = {sum_q[23:0], 1'b0};
                    exp_d   = exp_q - 9'd1;
                    shift_d = shift_q + 5'd1;
                    state_d = NORM;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            sign_q     <= 1'b0;
            sum_q      <= 25'd0;
            inf_flag_q <= 1'b0;
            exp_q      <= 9'd0;
            shift_q    <= 5'd0;
            result_q   <= 32'd0;
            zero_q     <= 1'b0;
            res_inf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sign_q     <= sign_d;
            sum_q      <= sum_d;
            inf_flag_q <= inf_flag_d;
            exp_q      <= exp_d;
            shift_q    <= shift_d;
            result_q   <= result_d;
            zero_q     <= zero_d;
            res_inf_q  <= res_inf_d;
        end
    end

    assign out_result = result_q;
    assign out_zero   = zero_q;
    assign out_inf    = res_inf_q;
    assign out_shift  = shift_q;

endmodule

// File: tb/tb_fp_norm_seq.sv
// Self-checking bench for fp_norm_seq: directed corner cases plus randomized operands against an arithmetic reference model.
module tb_fp_norm_seq;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_sum;
    logic        in_inf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic        out_inf;
    logic [4:0]  out_shift;

    int total = 0;
    int bad   = 0;

    fp_norm_seq dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_sum     (in_sum),
        .in_inf     (in_inf),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_zero   (out_zero),
        .out_inf    (out_inf),
        .out_shift  (out_shift)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference: locate the leading one, then normalize as far as the exponent floor allows.
    // Packed return: {zero, inf, shift[4:0], result[31:0]}.
    function automatic logic [38:0] refModel(input logic sgn, input logic [7:0] e,
                                             input logic [24:0] s, input logic inf);
        int ee;
        int msb;
        int need;
        int n;
        logic [24:0] shifted;
        ee = (e == 0) ? 1 : int'(e);
        if (inf) return {1'b0, 1'b1, 5'd0, sgn, 8'hFF, 23'd0};
        if (s == 0) return {1'b1, 1'b0, 5'd0, sgn, 8'h00, 23'd0};
        if (s[24]) begin
            if (ee + 1 == 255) return {1'b0, 1'b1, 5'd0, sgn, 8'hFF, 23'd0};
            return {1'b0, 1'b0, 5'd0, sgn, 8'(ee + 1), s[23:1]};
        end
        msb = 0;
        for (int i = 0; i < 24; i++) if (s[i]) msb = i;
        need = 23 - msb;
        if (need <= ee - 1) begin
            shifted = s << need;
            return {1'b0, 1'b0, 5'(need), sgn, 8'(ee - need), shifted[22:0]};
        end
        n = ee - 1;
        shifted = s << n;
        return {1'b0, 1'b0, 5'(n), sgn, 8'h00, shifted[22:0]};
    endfunction

    task automatic applyStimulus(input string tag, input logic sgn, input logic [7:0] e,
                                 input logic [24:0] s, input logic inf, input int stall);
        logic [38:0] expv;
        logic [31:0] held;
        int cycles;
        expv = refModel(sgn, e, s, inf);
        @(negedge clk);
        checkOutput({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_sign  = sgn;
        in_exp   = e;
        in_sum   = s;
        in_inf   = inf;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_sum   = $urandom;
        cycles   = 0;
        while (!out_valid && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        checkOutput({tag, ".latency"}, 32'(cycles), 32'(expv[36:32]) + 32'd1);
        checkOutput({tag, ".result"}, out_result, expv[31:0]);
        checkOutput({tag, ".zero"}, 32'(out_zero), 32'(expv[38]));
        checkOutput({tag, ".inf"}, 32'(out_inf), 32'(expv[37]));
        checkOutput({tag, ".shift"}, 32'(out_shift), 32'(expv[36:32]));
        checkOutput({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        held = out_result;
        for (int k = 0; k < stall; k++) begin
            @(posedge clk);
            #1;
            checkOutput({tag, ".stall_valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, ".stall_result"}, out_result, held);
            checkOutput({tag, ".stall_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        checkOutput({tag, ".drained"}, 32'(out_valid), 32'd0);
        checkOutput({tag, ".ready_again"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        logic [24:0] r;
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_sign   = 1'b0;
        in_exp    = 8'd0;
        in_sum    = 25'd0;
        in_inf    = 1'b0;
        out_ready = 1'b0;
        #12;
        checkOutput("rst.in_ready", 32'(in_ready), 32'd1);
        checkOutput("rst.out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst.result", out_result, 32'd0);
        checkOutput("rst.flags", {30'd0, out_zero, out_inf}, 32'd0);
        checkOutput("rst.shift", 32'(out_shift), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus("carry", 1'b0, 8'h7F, 25'h1000000, 1'b0, 0);
        checkOutput("carry.fixed", out_result, 32'h40000000);
        applyStimulus("cancel", 1'b0, 8'h8C, 25'h01F4000, 1'b0, 1);
        checkOutput("cancel.fixed", out_result, 32'h44FA0000);
        applyStimulus("zero", 1'b1, 8'h8B, 25'h0, 1'b0, 0);
        checkOutput("zero.fixed", out_result, 32'h80000000);
        applyStimulus("inf_flag", 1'b0, 8'h40, 25'h0ABCDEF, 1'b1, 0);
        checkOutput("inf_flag.fixed", out_result, 32'h7F800000);
        applyStimulus("ovf", 1'b0, 8'hFE, 25'h1000000, 1'b0, 0);
        checkOutput("ovf.fixed", out_result, 32'h7F800000);
        applyStimulus("denorm", 1'b0, 8'h03, 25'h0000010, 1'b0, 0);
        checkOutput("denorm.fixed", out_result, 32'h00000040);
        applyStimulus("in_denorm", 1'b1, 8'h00, 25'h0012345, 1'b0, 0);
        applyStimulus("deep", 1'b0, 8'hC8, 25'h0000001, 1'b0, 0);
        applyStimulus("backpressure", 1'b1, 8'h81, 25'h0300000, 1'b0, 5);

        // Abort mid-normalization and confirm nothing stale appears afterwards.
        @(negedge clk);
        in_valid = 1'b1;
        in_sign  = 1'b0;
        in_exp   = 8'h8C;
        in_sum   = 25'h01F4000;
        in_inf   = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("abort.out_valid", 32'(out_valid), 32'd0);
        checkOutput("abort.in_ready", 32'(in_ready), 32'd1);
        checkOutput("abort.result", out_result, 32'd0);
        checkOutput("abort.shift", 32'(out_shift), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            checkOutput("abort.no_stale", 32'(out_valid), 32'd0);
        end
        out_ready = 1'b0;

        for (int t = 0; t < 60; t++) begin
            r = 25'($urandom) >> $urandom_range(0, 24);
            if ($urandom_range(0, 7) == 0) r = 25'd0;
            applyStimulus("rand", 1'($urandom), 8'($urandom_range(0, 254)), r,
                          ($urandom_range(0, 15) == 0), $urandom_range(0, 3));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        bad++;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
